// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_CNT_W = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mdu_busy_timer.sv
// rtl/mdu_busy_timer.sv - tracks one in-flight mult/div for MDU_LAT cycles after issue
module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_LAT - 1);

    mdu_state_e           state;
    logic [MDU_CNT_W-1:0] cnt;

    // A start while already busy is ignored; the issuing stage must never do this.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= LOAD_VAL;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush control for PC, IF/ID and ID/EX plus stall-cycle counter
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             id_mdu_access,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_mdu_start,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             if_en,
    output logic             if_clr,
    output logic             id_en,
    output logic             id_clr,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic loadUse;
    logic mduHazard;
    logic stall;
    logic flush;

    mdu_busy_timer #(
        .MDU_LAT(MDU_LAT)
    ) uBusyTimer (
        .clk  (clk),
        .rst  (rst),
        .start(ex_mdu_start),
        .busy (mdu_busy)
    );

    assign loadUse = ex_mem_read && (ex_rt_addr != REG_ZERO) &&
                     ((ex_rt_addr == id_rs_addr) ||
                      (id_uses_rt && (ex_rt_addr == id_rt_addr)));

    // ex_mdu_start covers the issue cycle itself, before mdu_busy rises.
    assign mduHazard = id_mdu_access && (mdu_busy || ex_mdu_start);

    assign stall = loadUse || mduHazard;
    assign flush = ex_branch_taken;

    // A taken branch wins: the held ID instruction is wrong-path anyway.
    assign pc_en  = flush || !stall;
    assign if_en  = flush || !stall;
    assign if_clr = flush;
    assign id_en  = 1'b1;
    assign id_clr = flush || stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall && !flush && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed bench for hazard_ctrl against a cycle-window model
module tb_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       id_rs_addr = '0;
    logic [4:0]       id_rt_addr = '0;
    logic             id_uses_rt = 1'b0;
    logic             id_mdu_access = 1'b0;
    logic             ex_mem_read = 1'b0;
    logic [4:0]       ex_rt_addr = '0;
    logic             ex_mdu_start = 1'b0;
    logic             ex_branch_taken = 1'b0;
    logic             pc_en;
    logic             if_en;
    logic             if_clr;
    logic             id_en;
    logic             id_clr;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(
        .MDU_LAT(LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_uses_rt     (id_uses_rt),
        .id_mdu_access  (id_mdu_access),
        .ex_mem_read    (ex_mem_read),
        .ex_rt_addr     (ex_rt_addr),
        .ex_mdu_start   (ex_mdu_start),
        .ex_branch_taken(ex_branch_taken),
        .pc_en          (pc_en),
        .if_en          (if_en),
        .if_clr         (if_clr),
        .id_en          (id_en),
        .id_clr         (id_clr),
        .mdu_busy       (mdu_busy),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && mdu_busy && ex_mdu_start) begin
            $error("illegal ex_mdu_start while MDU busy");
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busyFrom = 1;
    int busyTo   = 0;
    int stallRef = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit refBusy();
        return (cyc >= busyFrom) && (cyc <= busyTo);
    endfunction

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                        input logic access, input logic memRead, input logic [4:0] exRt,
                        input logic start, input logic taken);
        bit lu, mh, st;
        @(negedge clk);
        id_rs_addr      = rs;
        id_rt_addr      = rt;
        id_uses_rt      = usesRt;
        id_mdu_access   = access;
        ex_mem_read     = memRead;
        ex_rt_addr      = exRt;
        ex_mdu_start    = start;
        ex_branch_taken = taken;
        #1;
        lu = memRead && (exRt != 0) && ((exRt == rs) || (usesRt && (exRt == rt)));
        mh = access && (refBusy() || start);
        st = lu || mh;
        chk("pc_en",        32'(pc_en),        32'(taken || !st));
        chk("if_en",        32'(if_en),        32'(taken || !st));
        chk("if_clr",       32'(if_clr),       32'(taken));
        chk("id_en",        32'(id_en),        32'd1);
        chk("id_clr",       32'(id_clr),       32'(taken || st));
        chk("mdu_busy",     32'(mdu_busy),     32'(refBusy()));
        chk("stall_cycles", 32'(stall_cycles), 32'(stallRef));
        @(posedge clk);
        if (st && !taken && stallRef < CMAX) stallRef++;
        if (start && !refBusy()) begin
            busyFrom = cyc + 1;
            busyTo   = cyc + LAT;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic quietInputs();
        id_rs_addr = '0; id_rt_addr = '0; id_uses_rt = 1'b0; id_mdu_access = 1'b0;
        ex_mem_read = 1'b0; ex_rt_addr = '0; ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        int base;
        logic startR;
        // reset state
        #2;
        chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("rst_stall",    32'(stall_cycles), 32'd0);
        chk("rst_pc_en",    32'(pc_en), 32'd1);
        chk("rst_id_clr",   32'(id_clr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // load-use on rs, then destination r0
        step(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 chk("lu_count", 32'(stall_cycles), 32'd1);
        step(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        // rt match only counts when rt is a source
        step(5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        idle(1);

        // MDU window with a HI/LO consumer waiting
        base = stallRef;
        step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < LAT + 1; i++) step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 chk("mdu_stall_len", 32'(stall_cycles), 32'(base + LAT + 1));
        idle(1);

        // flush beats load-use, counter unchanged
        base = stallRef;
        step(5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        #1 chk("flush_count", 32'(stall_cycles), 32'(base));

        // async reset in the middle of a busy window
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        quietInputs();
        #2 rst = 1'b0;
        #1;
        chk("arst_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("arst_stall",    32'(stall_cycles), 32'd0);
        busyFrom = 1; busyTo = 0; stallRef = 0;
        @(negedge clk);
        rst = 1'b1;
        step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < LAT + 1; i++) step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 chk("restart_len", 32'(stall_cycles), 32'(LAT + 1));

        // randomized traffic with a small register pool so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            startR = ($urandom_range(0, 5) == 0) && !refBusy();
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), startR, 1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
